// File: rtl/uart_fifo_loopback.sv
// uart_fifo_loopback
//   Buffered, mode-selectable UART loopback. A uart_rx feeds a FIFO_DEPTH-byte
//   RX FIFO. A small launch FSM feeds uart_tx.
//   Loop mode (i_Loop_En=1): queued bytes are re-transmitted in arrival order.
//   Host mode (i_Loop_En=0): the FIFO drains through a show-ahead valid/ready
//   byte port. TX is fed from a separate valid/ready port.
//   Optional feature macro: UART_LB_CASE_FLIP_EN. When it is defined, loop mode
//   flips the case of ASCII letters (bit 5) at launch.
//
// Ports
//   i_Clock, i_Reset        clock; asynchronous active-high reset (top-level state only)
//   i_Rx_Serial             UART serial input
//   o_Tx_Serial/Active/Done uart_tx line, busy flag, one-cycle done pulse
//   i_Loop_En               1 = loop mode, 0 = host mode (sampled in IDLE only)
//   o_Rx_Byte/o_Rx_Valid/i_Rx_Ready   host-side FIFO drain port (show-ahead)
//   i_Tx_Byte/i_Tx_Valid/o_Tx_Ready   host-side transmit port
//   o_Fifo_Count            bytes currently held in the FIFO
//   o_Overflow              sticky drop flag; i_Clear_Overflow clears it (a new drop wins)

// UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rx_dv.
// This block has no reset, so a frame in flight always completes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic [1:0]       sync_q, sync_d;

  always_ff @(posedge clk) begin
    sync_q  <= sync_d;
    state_q <= state_d;
    cnt_q   <= cnt_d;
    idx_q   <= idx_d;
    data_q  <= data_d;
    dv_q    <= dv_d;
  end

  always_comb begin
    sync_d  = {sync_q[0], rx_serial};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!sync_q[1]) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in; a glitch returns to idle.
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = sync_q[1] ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d         = '0;
          data_d[idx_q] = sync_q[1];
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d   = '0;
            state_d = RX_STOP;
          end
        end
      end
      default: begin // RX_STOP
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          dv_d    = 1'b1;
          state_d = RX_IDLE;
        end
      end
    endcase
  end

  assign rx_dv   = dv_q;
  assign rx_byte = data_q;
endmodule

// UART transmitter, 8N1. tx_active rises the cycle after tx_dv. It falls
// together with the one-cycle tx_done pulse at the end of the stop bit.
// This block has no reset.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    idx_q    <= idx_d;
    data_q   <= data_d;
    serial_q <= serial_d;
    active_q <= active_d;
    done_q   <= done_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        serial_d = 1'b1;
        cnt_d    = '0;
        idx_d    = '0;
        if (tx_dv) begin
          data_d   = tx_byte;
          active_d = 1'b1;
          serial_d = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d    = '0;
          serial_d = data_q[0];
          state_d  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            serial_d = data_q[idx_q + 3'd1];
          end else begin
            idx_d    = '0;
            serial_d = 1'b1;
            state_d  = TX_STOP;
          end
        end
      end
      default: begin // TX_STOP
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = TX_IDLE;
        end
      end
    endcase
  end

  assign tx_active = active_q;
  assign tx_serial = serial_q;
  assign tx_done   = done_q;
endmodule

module uart_fifo_loopback #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Rx_Serial,
  output logic                            o_Tx_Serial,
  output logic                            o_Tx_Active,
  output logic                            o_Tx_Done,
  input  logic                            i_Loop_En,
  output logic [7:0]                      o_Rx_Byte,
  output logic                            o_Rx_Valid,
  input  logic                            i_Rx_Ready,
  input  logic [7:0]                      i_Tx_Byte,
  input  logic                            i_Tx_Valid,
  output logic                            o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Fifo_Count,
  output logic                            o_Overflow,
  input  logic                            i_Clear_Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_COOL} lb_state_t;

  logic       rx_dv;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (i_Clock),
    .rx_serial (i_Rx_Serial),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte)
  );

  // FIFO storage. The head is read combinationally so the host port is show-ahead.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  lb_state_t     state_q, state_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;

  logic       empty, full, host_pop, fsm_pop, pop, wr_en;
  logic [7:0] head, loop_byte;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign head  = mem_q[rd_ptr_q];

`ifdef UART_LB_CASE_FLIP_EN
  // ASCII letters get bit 5 inverted on the loop path only; FIFO contents are untouched.
  logic is_letter;
  assign is_letter = ((head >= 8'h41) && (head <= 8'h5A)) ||
                     ((head >= 8'h61) && (head <= 8'h7A));
  assign loop_byte = is_letter ? (head ^ 8'h20) : head;
`else
  assign loop_byte = head;
`endif

  assign o_Rx_Valid = !empty && !i_Loop_En;
  assign o_Rx_Byte  = head;
  assign o_Tx_Ready = !i_Loop_En && (state_q == ST_IDLE) && !o_Tx_Active;
  assign host_pop   = o_Rx_Valid && i_Rx_Ready;
  assign pop        = host_pop || fsm_pop;
  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign wr_en      = rx_dv && (!full || pop);

  // Launch FSM. Launch only when uart_tx is idle. This also covers a reset
  // that lands mid-frame, because uart_tx itself keeps running.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    fsm_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Loop_En) begin
          if (!empty && !o_Tx_Active) begin
            fsm_pop   = 1'b1;
            tx_byte_d = loop_byte;
            tx_dv_d   = 1'b1;
            state_d   = ST_LAUNCH;
          end
        end else if (i_Tx_Valid && o_Tx_Ready) begin
          tx_byte_d = i_Tx_Byte;
          tx_dv_d   = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (o_Tx_Done) state_d = ST_COOL;
      default:   state_d = ST_IDLE; // ST_COOL: one guard cycle
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear request leaves the flag set.
    overflow_d = overflow_q;
    if (rx_dv && !wr_en)        overflow_d = 1'b1;
    else if (i_Clear_Overflow)  overflow_d = 1'b0;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign o_Fifo_Count = count_q;
  assign o_Overflow   = overflow_q;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk       (i_Clock),
    .tx_dv     (tx_dv_q),
    .tx_byte   (tx_byte_q),
    .tx_active (o_Tx_Active),
    .tx_serial (o_Tx_Serial),
    .tx_done   (o_Tx_Done)
  );
endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Testbench for uart_fifo_loopback (CLKS_PER_BIT=8, FIFO_DEPTH=16).
// Expected TX frames and host pops are queued by the stimulus. Separate monitor
// processes decode o_Tx_Serial and watch the host pop port, and they compare
// against those queues.
module tb_uart_fifo_loopback;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef UART_LB_CASE_FLIP_EN
  localparam logic [7:0] EXP_T1  = 8'h75;
  localparam logic [7:0] EXP_T6A = 8'h41;
`else
  localparam logic [7:0] EXP_T1  = 8'h55;
  localparam logic [7:0] EXP_T6A = 8'h61;
`endif

  logic          clk = 1'b0;
  logic          i_Reset, i_Rx_Serial, i_Loop_En, i_Rx_Ready, i_Tx_Valid, i_Clear_Overflow;
  logic [7:0]    i_Tx_Byte;
  logic          o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_Valid, o_Tx_Ready, o_Overflow;
  logic [7:0]    o_Rx_Byte;
  logic [CW-1:0] o_Fifo_Count;

  always #5 clk = ~clk;

  uart_fifo_loopback #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
    .i_Clock          (clk),
    .i_Reset          (i_Reset),
    .i_Rx_Serial      (i_Rx_Serial),
    .o_Tx_Serial      (o_Tx_Serial),
    .o_Tx_Active      (o_Tx_Active),
    .o_Tx_Done        (o_Tx_Done),
    .i_Loop_En        (i_Loop_En),
    .o_Rx_Byte        (o_Rx_Byte),
    .o_Rx_Valid       (o_Rx_Valid),
    .i_Rx_Ready       (i_Rx_Ready),
    .i_Tx_Byte        (i_Tx_Byte),
    .i_Tx_Valid       (i_Tx_Valid),
    .o_Tx_Ready       (o_Tx_Ready),
    .o_Fifo_Count     (o_Fifo_Count),
    .o_Overflow       (o_Overflow),
    .i_Clear_Overflow (i_Clear_Overflow)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         done_pulses  = 0;
  bit         mon_en       = 1'b0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] sh;
    sh = b;
    i_Rx_Serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = sh[0];
      sh = sh >> 1;
      tick(CPB);
    end
    i_Rx_Serial = 1'b1;
    tick(CPB);
    tick(2);
  endtask

  task automatic wait_tx_drain(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (tx_exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(tx_exp_q.size()), 32'd0);
  endtask

  // Serial TX monitor: decodes each frame at mid-bit and compares it with the queue.
  initial begin : tx_mon
    logic [7:0] b;
    logic       ok;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (o_Tx_Serial === 1'b0) begin
        ok = 1'b1;
        b  = 8'h00;
        repeat (CPB/2 - 1) @(negedge clk);
        if (o_Tx_Serial !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b = {o_Tx_Serial, b[7:1]};
        end
        repeat (CPB) @(negedge clk);
        if (o_Tx_Serial !== 1'b1) ok = 1'b0;
        check("tx_framing", 32'(ok), 32'd1);
        if (tx_exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
        end else begin
          check("tx_frame", 32'(b), 32'(tx_exp_q.pop_front()));
        end
      end
    end
  end

  // Host pop monitor: a pop happens at the next rising edge whenever valid & ready.
  initial begin : rx_mon
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (o_Rx_Valid && i_Rx_Ready) begin
        if (rx_exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL rx_unexpected_pop: got 0x%0h, expected no pop", o_Rx_Byte);
        end else begin
          check("rx_pop", 32'(o_Rx_Byte), 32'(rx_exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (o_Tx_Done === 1'b1) done_pulses++;
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int late_active;
    i_Reset = 1'b1; i_Rx_Serial = 1'b1; i_Loop_En = 1'b0; i_Rx_Ready = 1'b0;
    i_Tx_Valid = 1'b0; i_Tx_Byte = 8'h00; i_Clear_Overflow = 1'b0;
    tick(5);
    i_Reset = 1'b0;
    tick(3);
    mon_en = 1'b1;

    // Reset state
    check("rst_count",    32'(o_Fifo_Count), 32'd0);
    check("rst_rx_valid", 32'(o_Rx_Valid),   32'd0);
    check("rst_overflow", 32'(o_Overflow),   32'd0);
    check("rst_tx_ready", 32'(o_Tx_Ready),   32'd1);

    // Loop mode, 0x55: count=1 at N+1, popped at N+2 (launch), tx busy from N+3
    i_Loop_En = 1'b1;
    tick(2);
    d0 = done_pulses;
    tx_exp_q.push_back(EXP_T1);
    fork
      send_byte(8'h55);
      begin
        for (int k = 0; k < 300; k++) begin
          if (o_Fifo_Count == 1) break;
          @(negedge clk);
        end
        check("t1_count_rise",    32'(o_Fifo_Count), 32'd1);
        check("t1_rx_valid_loop", 32'(o_Rx_Valid),   32'd0);
        @(negedge clk);
        check("t1_popped_at_launch", 32'(o_Fifo_Count), 32'd0);
        check("t1_active_launch",    32'(o_Tx_Active),  32'd0);
        @(negedge clk);
        check("t1_active_after",     32'(o_Tx_Active),  32'd1);
      end
    join
    wait_tx_drain("t1_tx_drain", 300);
    tick(8);
    check("t1_done_pulses", 32'(done_pulses - d0), 32'd1);

    // Host mode, 17 bytes into a 16-deep FIFO with nobody popping
    i_Loop_En = 1'b0;
    tick(4);
    for (int b = 0; b <= 16; b++) begin
      if (b < 16) rx_exp_q.push_back(8'(b));
      send_byte(8'(b));
    end
    check("t2_count_full", 32'(o_Fifo_Count), 32'd16);
    check("t2_overflow",   32'(o_Overflow),   32'd1);
    check("t2_head_byte",  32'(o_Rx_Byte),    32'h00);

    // Overflow clear with no drop, then clear held across a dropped byte
    i_Clear_Overflow = 1'b1;
    tick(1);
    i_Clear_Overflow = 1'b0;
    check("t3_clear_no_drop", 32'(o_Overflow), 32'd0);
    i_Clear_Overflow = 1'b1;
    fork
      send_byte(8'h11);
      begin
        for (int k = 0; k < 300; k++) begin
          if (o_Overflow == 1'b1) break;
          @(negedge clk);
        end
        i_Clear_Overflow = 1'b0;
        check("t3_set_wins", 32'(o_Overflow), 32'd1);
      end
    join
    tick(3);
    check("t3_sticky",     32'(o_Overflow),   32'd1);
    check("t3_count_full", 32'(o_Fifo_Count), 32'd16);
    i_Clear_Overflow = 1'b1;
    tick(1);
    i_Clear_Overflow = 1'b0;
    check("t3_cleared", 32'(o_Overflow), 32'd0);

    // Drain the FIFO through the host port: 0x00..0x0F in order
    i_Rx_Ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (o_Fifo_Count == 0) break;
      @(negedge clk);
    end
    i_Rx_Ready = 1'b0;
    check("t2_count_empty", 32'(o_Fifo_Count),    32'd0);
    check("t2_all_popped",  32'(rx_exp_q.size()), 32'd0);
    check("t2_valid_empty", 32'(o_Rx_Valid),      32'd0);

    // Host TX of 0xA5
    tick(2);
    check("t4_ready_idle", 32'(o_Tx_Ready), 32'd1);
    tx_exp_q.push_back(8'hA5);
    i_Tx_Byte  = 8'hA5;
    i_Tx_Valid = 1'b1;
    tick(1);
    i_Tx_Valid = 1'b0;
    check("t4_ready_fell", 32'(o_Tx_Ready), 32'd0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_Tx_Done == 1'b1) break;
    end
    check("t4_done_seen", 32'(o_Tx_Done), 32'd1);
    @(negedge clk);
    check("t4_ready_done_p1", 32'(o_Tx_Ready), 32'd0);
    @(negedge clk);
    check("t4_ready_done_p2", 32'(o_Tx_Ready), 32'd1);
    wait_tx_drain("t4_tx_drain", 50);

    // Loop mode, 0x61 then 0x31
    i_Loop_En = 1'b1;
    tx_exp_q.push_back(EXP_T6A);
    tx_exp_q.push_back(8'h31);
    send_byte(8'h61);
    send_byte(8'h31);
    wait_tx_drain("t6_tx_drain", 600);
    tick(12);

    // Three bytes queued, loop starts, reset lands in the TX data bits
    i_Loop_En = 1'b0;
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    check("t5_count3",      32'(o_Fifo_Count), 32'd3);
    check("t5_valid_host",  32'(o_Rx_Valid),   32'd1);
    tx_exp_q.push_back(8'h21);
    i_Loop_En = 1'b1;
    #1;
    check("t5_valid_loop",  32'(o_Rx_Valid),   32'd0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_Tx_Active == 1'b1) break;
    end
    check("t5_launched",    32'(o_Tx_Active),  32'd1);
    check("t5_count2",      32'(o_Fifo_Count), 32'd2);
    repeat (20) @(negedge clk);
    i_Reset = 1'b1;
    #1;
    check("t5_rst_count",   32'(o_Fifo_Count), 32'd0);
    @(negedge clk);
    i_Reset = 1'b0;
    #1;
    check("t5_count_after",    32'(o_Fifo_Count), 32'd0);
    check("t5_overflow_after", 32'(o_Overflow),   32'd0);
    check("t5_frame_continues", 32'(o_Tx_Active), 32'd1);
    for (int k = 0; k < 200; k++) begin
      if (o_Tx_Active == 1'b0) break;
      @(negedge clk);
    end
    check("t5_active_fell", 32'(o_Tx_Active), 32'd0);
    late_active = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_Tx_Active) late_active++;
    end
    check("t5_no_relaunch", 32'(late_active),  32'd0);
    check("t5_count_final", 32'(o_Fifo_Count), 32'd0);
    wait_tx_drain("t5_tx_drain", 20);
    check("final_rx_queue", 32'(rx_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
